// File: rtl/lvds_stat_pkg.sv
// Shared constants, state encoding and byte-select helper for the LVDS statistics reporter.
package lvds_stat_pkg;

   localparam int unsigned FRAME_LEN = 20;
   localparam int unsigned IDX_SEQ   = 1;
   localparam int unsigned IDX_FLAG  = 2;
   localparam int unsigned IDX_ERR0  = 3;
   localparam int unsigned IDX_RECV0 = 11;
   localparam int unsigned IDX_CSUM  = 19;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   // Byte k of a 64-bit word, k=0 being the most significant byte.
   function automatic logic [7:0] sel_byte(input logic [63:0] w, input logic [2:0] k);
      return w[{3'd7 - k, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/lvds_stat_report_if.sv
// Valid/ready byte stream carrying report frames towards the UART transmitter.
interface lvds_stat_report_if;

   logic [7:0] DOUT;
   logic       DOVALID;
   logic       DOREADY;

   modport master (output DOUT, output DOVALID, input DOREADY);
   modport slave  (input DOUT, input DOVALID, output DOREADY);

endinterface

// File: rtl/stat_period_timer.sv
// Free-running period timer; TICK marks the last cycle of each PERIOD while ENABLE is high.
module stat_period_timer #(
   parameter int unsigned PERIOD = 100_000_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic ENABLE,
   output logic TICK
);

   localparam int unsigned TW = $clog2(PERIOD);
   localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

   logic [TW-1:0] timer_q, timer_d;

   assign TICK = ENABLE && (timer_q == LAST);

   always_comb begin
      timer_d = timer_q + 1'b1;
      if (!ENABLE || TICK) timer_d = '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) timer_q <= '0;
      else     timer_q <= timer_d;
   end

endmodule

// File: rtl/lvds_stat_report.sv
// Snapshots the checker counters on a tick or START and streams them as a 20-byte
// checksummed frame over a valid/ready byte interface.
module lvds_stat_report
   import lvds_stat_pkg::*;
#(
   parameter int unsigned PERIOD    = 100_000_000,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      ENABLE,
   input  logic                      START,
   input  logic [63:0]               ERR_CNT,
   input  logic [57:0]               RECV_CNT,
   input  logic                      ALIGNED,
   lvds_stat_report_if.master        dout_if,
   output logic                      BUSY,
   output logic [15:0]               DROP_CNT
);

   localparam int unsigned IDX_W = $clog2(FRAME_LEN);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       csum_q;
   logic [7:0]       seq_q;
   logic [7:0]       seq_lat_q;
   logic [63:0]      err_q;
   logic [57:0]      recv_q;
   logic             aligned_q;
   logic [15:0]      drop_q;

   logic       tick;
   logic       trigger;
   logic       sending;
   logic       accept;
   logic       last;
   logic [7:0] frame_byte;

   stat_period_timer #(
      .PERIOD (PERIOD)
   ) u_timer (
      .CLK    (CLK),
      .RST    (RST),
      .ENABLE (ENABLE),
      .TICK   (tick)
   );

   // A coincident tick and START collapse into a single trigger.
   assign trigger = tick | START;
   assign sending = (state_q == ST_SEND);
   assign accept  = sending && dout_if.DOREADY;
   assign last    = (idx_q == IDX_W'(IDX_CSUM));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (trigger) state_d = ST_SEND;
         ST_SEND: if (accept && last) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dout_if.DOVALID = sending;
      BUSY            = sending;
      dout_if.DOUT    = sending ? frame_byte : 8'h00;
      DROP_CNT        = drop_q;
   end

   // Frame content is drawn only from the shadow registers, so the inputs may move freely.
   always_comb begin
      frame_byte = csum_q;
      if (idx_q == IDX_W'(0)) begin
         frame_byte = SYNC_BYTE;
      end else if (idx_q == IDX_W'(IDX_SEQ)) begin
         frame_byte = seq_lat_q;
      end else if (idx_q == IDX_W'(IDX_FLAG)) begin
         frame_byte = {7'b0, aligned_q};
      end else if (idx_q < IDX_W'(IDX_RECV0)) begin
         frame_byte = sel_byte(err_q, 3'(idx_q - IDX_W'(IDX_ERR0)));
      end else if (idx_q < IDX_W'(IDX_CSUM)) begin
         frame_byte = sel_byte({6'b0, recv_q}, 3'(idx_q - IDX_W'(IDX_RECV0)));
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx_q     <= '0;
         csum_q    <= 8'h00;
         seq_q     <= 8'h00;
         seq_lat_q <= 8'h00;
         err_q     <= 64'h0;
         recv_q    <= 58'h0;
         aligned_q <= 1'b0;
         drop_q    <= 16'h0000;
      end else begin
         if (!sending && trigger) begin
            err_q     <= ERR_CNT;
            recv_q    <= RECV_CNT;
            aligned_q <= ALIGNED;
            seq_lat_q <= seq_q;
            seq_q     <= seq_q + 8'd1;
            idx_q     <= '0;
            csum_q    <= 8'h00;
         end
         if (accept) begin
            csum_q <= csum_q ^ frame_byte;
            idx_q  <= idx_q + 1'b1;
         end
         // Triggers arriving during a frame, including its final accept cycle, are lost.
         if (sending && trigger && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_lvds_stat_report.sv
// Directed self-checking bench for lvds_stat_report with a short report period.
module tb_lvds_stat_report;
   import lvds_stat_pkg::*;

   localparam int unsigned PERIOD = 50;
   typedef logic [7:0] frame_t [FRAME_LEN];

   logic        CLK = 1'b0;
   logic        RST;
   logic        ENABLE;
   logic        START;
   logic [63:0] ERR_CNT;
   logic [57:0] RECV_CNT;
   logic        ALIGNED;
   logic        BUSY;
   logic [15:0] DROP_CNT;

   int nchk = 0;
   int nfail = 0;

   lvds_stat_report_if bus ();

   lvds_stat_report #(
      .PERIOD    (PERIOD),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .ENABLE   (ENABLE),
      .START    (START),
      .ERR_CNT  (ERR_CNT),
      .RECV_CNT (RECV_CNT),
      .ALIGNED  (ALIGNED),
      .dout_if  (bus),
      .BUSY     (BUSY),
      .DROP_CNT (DROP_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic model_frame(input logic [63:0] e, input logic [57:0] r, input logic a,
                              input logic [7:0] s, output frame_t f);
      logic [63:0] rx;
      logic [7:0]  x;
      rx   = {6'b0, r};
      f[0] = 8'hA5;
      f[1] = s;
      f[2] = {7'b0, a};
      for (int i = 0; i < 8; i++) begin
         f[3 + i]  = e[63 - 8 * i -: 8];
         f[11 + i] = rx[63 - 8 * i -: 8];
      end
      x = 8'h00;
      for (int i = 0; i < 19; i++) x ^= f[i];
      f[19] = x;
   endtask

   function automatic int frame_diff(input frame_t a, input frame_t b);
      for (int i = 0; i < FRAME_LEN; i++) if (a[i] !== b[i]) return i;
      return -1;
   endfunction

   task automatic do_reset();
      RST          = 1'b1;
      ENABLE       = 1'b0;
      START        = 1'b0;
      ALIGNED      = 1'b0;
      ERR_CNT      = 64'h0;
      RECV_CNT     = 58'h0;
      bus.DOREADY  = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   // Called at a negedge; optionally pulses START, then accepts bytes n0..n_stop-1.
   task automatic collect(input bit pulse_start, input int low_pct, input int n0,
                          input int n_stop, input int budget, inout frame_t f,
                          output int first_valid, output int cycles,
                          output bit stable_ok, output bit timeout);
      logic [7:0] prev;
      bit         stalled;
      int         n;
      n           = n0;
      first_valid = -1;
      cycles      = 0;
      stable_ok   = 1'b1;
      timeout     = 1'b0;
      stalled     = 1'b0;
      prev        = 8'h00;
      if (pulse_start) START = 1'b1;
      while (n < n_stop) begin
         @(negedge CLK);
         START = 1'b0;
         cycles++;
         if (cycles > budget) begin
            timeout = 1'b1;
            break;
         end
         if (bus.DOVALID) begin
            if (first_valid < 0) first_valid = cycles;
            if (stalled && bus.DOUT !== prev) stable_ok = 1'b0;
            prev = bus.DOUT;
            if (low_pct > 0 && $urandom_range(99) < low_pct) begin
               bus.DOREADY = 1'b0;
               stalled     = 1'b1;
            end else begin
               bus.DOREADY = 1'b1;
               stalled     = 1'b0;
               f[n]        = bus.DOUT;
               n++;
            end
         end else begin
            if (stalled) stable_ok = 1'b0;
            bus.DOREADY = (low_pct == 0) ? 1'b1 : 1'($urandom_range(1));
         end
      end
   endtask

   task automatic test_reset();
      int bad;
      do_reset();
      nchk++;
      if (bus.DOVALID !== 1'b0 || BUSY !== 1'b0 || bus.DOUT !== 8'h00 || DROP_CNT !== 16'h0) begin
         nfail++;
         $display("FAIL reset_outputs: got dovalid=%b busy=%b dout=%h drop=%h, want 0 0 00 0000",
                  bus.DOVALID, BUSY, bus.DOUT, DROP_CNT);
      end
      bad = 0;
      repeat (200) begin
         @(negedge CLK);
         if (bus.DOVALID !== 1'b0 || BUSY !== 1'b0) bad++;
      end
      nchk++;
      if (bad != 0 || DROP_CNT !== 16'h0) begin
         nfail++;
         $display("FAIL idle_quiet: got %0d active cycles drop=%h, want 0 and 0000", bad, DROP_CNT);
      end
   endtask

   task automatic test_frame(input int low_pct, input string tag);
      frame_t exp, got;
      int fv, cyc, d;
      bit st, to;
      exp = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD,
              8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hA5};
      do_reset();
      ERR_CNT     = 64'h0123456789ABCDEF;
      RECV_CNT    = 58'h1;
      ALIGNED     = 1'b1;
      bus.DOREADY = 1'b1;
      collect(1'b1, low_pct, 0, FRAME_LEN, 600, got, fv, cyc, st, to);
      d = frame_diff(got, exp);
      nchk++;
      if (to || d >= 0) begin
         nfail++;
         $display("FAIL %s_bytes: timeout=%0b first bad idx=%0d got=%h want=%h", tag, to, d,
                  (d >= 0) ? got[d] : 8'h00, (d >= 0) ? exp[d] : 8'h00);
      end
      nchk++;
      if (fv != 1) begin
         nfail++;
         $display("FAIL %s_latency: got DOVALID first at cycle %0d, want 1", tag, fv);
      end
      if (low_pct == 0) begin
         nchk++;
         if (cyc != 20) begin
            nfail++;
            $display("FAIL %s_duration: got %0d cycles, want 20", tag, cyc);
         end
      end else begin
         nchk++;
         if (!st) begin
            nfail++;
            $display("FAIL %s_stable: DOUT/DOVALID changed during stall, got 0 want 1", tag);
         end
      end
      @(negedge CLK);
      nchk++;
      if (bus.DOVALID !== 1'b0 || BUSY !== 1'b0 || DROP_CNT !== 16'h0) begin
         nfail++;
         $display("FAIL %s_end: got dovalid=%b busy=%b drop=%h, want 0 0 0000", tag,
                  bus.DOVALID, BUSY, DROP_CNT);
      end
   endtask

   task automatic test_periodic();
      int starts[3];
      logic [7:0] seqs[3];
      int ns, w;
      bit pv, rose;
      do_reset();
      ERR_CNT     = 64'h5;
      RECV_CNT    = 58'h7;
      bus.DOREADY = 1'b1;
      ENABLE      = 1'b1;
      ns = 0; pv = 1'b0; rose = 1'b0;
      for (int i = 1; i <= 160; i++) begin
         @(negedge CLK);
         if (rose && ns > 0 && ns <= 3) seqs[ns - 1] = bus.DOUT;
         rose = bus.DOVALID && !pv;
         if (rose) begin
            if (ns < 3) starts[ns] = i;
            ns++;
         end
         pv = bus.DOVALID;
      end
      nchk++;
      if (ns != 3) begin
         nfail++;
         $display("FAIL periodic_count: got %0d frames, want 3", ns);
      end else begin
         for (int k = 0; k < 3; k++) begin
            nchk++;
            if (starts[k] != 50 * (k + 1) || seqs[k] !== 8'(k)) begin
               nfail++;
               $display("FAIL periodic_frame%0d: got start=%0d seq=%h, want start=%0d seq=%h",
                        k, starts[k], seqs[k], 50 * (k + 1), 8'(k));
            end
         end
      end
      ENABLE = 1'b0;
      w = 0;
      while (BUSY && w < 40) begin
         @(negedge CLK);
         w++;
      end
      nchk++;
      if (BUSY !== 1'b0 || DROP_CNT !== 16'h0) begin
         nfail++;
         $display("FAIL periodic_drain: got busy=%b drop=%h, want 0 0000", BUSY, DROP_CNT);
      end
   endtask

   task automatic test_drop();
      frame_t exp, got;
      int fv, cyc, d;
      bit st, to;
      do_reset();
      ERR_CNT     = 64'hFEDC_BA98_7654_3210;
      RECV_CNT    = 58'h2AB_CDEF_0123_4567;
      ALIGNED     = 1'b0;
      model_frame(ERR_CNT, RECV_CNT, ALIGNED, 8'h00, exp);
      bus.DOREADY = 1'b1;
      collect(1'b1, 0, 0, 5, 50, got, fv, cyc, st, to);
      ERR_CNT  = 64'h1111_2222_3333_4444;
      RECV_CNT = 58'h0;
      ALIGNED  = 1'b1;
      @(negedge CLK);
      bus.DOREADY = 1'b0;
      START       = 1'b1;
      @(negedge CLK);
      START  = 1'b0;
      ENABLE = 1'b1;
      nchk++;
      if (DROP_CNT !== 16'd1 || bus.DOUT !== exp[5] || bus.DOVALID !== 1'b1) begin
         nfail++;
         $display("FAIL drop_start: got drop=%h dout=%h valid=%b, want 0001 %h 1", DROP_CNT,
                  bus.DOUT, bus.DOVALID, exp[5]);
      end
      repeat (49) @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START  = 1'b0;
      ENABLE = 1'b0;
      nchk++;
      if (DROP_CNT !== 16'd2 || bus.DOUT !== exp[5]) begin
         nfail++;
         $display("FAIL drop_tick_start: got drop=%h dout=%h, want 0002 %h", DROP_CNT,
                  bus.DOUT, exp[5]);
      end
      collect(1'b0, 0, 5, FRAME_LEN, 50, got, fv, cyc, st, to);
      got[0] = 8'hA5; got[1] = 8'h00; got[2] = 8'h00;
      got[3] = 8'hFE; got[4] = 8'hDC;
      d = frame_diff(got, exp);
      nchk++;
      if (to || d >= 0 || DROP_CNT !== 16'd2) begin
         nfail++;
         $display("FAIL drop_frame: timeout=%0b bad idx=%0d drop=%h, want -1 and 0002", to, d,
                  DROP_CNT);
      end
   endtask

   task automatic test_reset_mid_frame();
      frame_t exp, got;
      int fv, cyc, d;
      bit st, to;
      do_reset();
      ERR_CNT     = 64'h1;
      RECV_CNT    = 58'h2;
      ALIGNED     = 1'b1;
      bus.DOREADY = 1'b1;
      collect(1'b1, 0, 0, FRAME_LEN, 50, got, fv, cyc, st, to);
      @(negedge CLK);
      collect(1'b1, 0, 0, 7, 50, got, fv, cyc, st, to);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      nchk++;
      if (bus.DOVALID !== 1'b0 || BUSY !== 1'b0) begin
         nfail++;
         $display("FAIL reset_abort: got dovalid=%b busy=%b, want 0 0", bus.DOVALID, BUSY);
      end
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      model_frame(ERR_CNT, RECV_CNT, ALIGNED, 8'h00, exp);
      collect(1'b1, 0, 0, FRAME_LEN, 50, got, fv, cyc, st, to);
      d = frame_diff(got, exp);
      nchk++;
      if (to || d >= 0) begin
         nfail++;
         $display("FAIL reset_seq: timeout=%0b bad idx=%0d got seq=%h want 00", to, d, got[1]);
      end
   endtask

   initial begin
      test_reset();
      test_frame(0, "frame");
      test_frame(30, "stall");
      test_periodic();
      test_drop();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
